// File: rtl/gpio_pkg.sv
// Shared register map for the AHB-Lite GPIO bank: per-port register offsets
// and the address stride between consecutive ports.
package gpio_pkg;

    localparam logic [4:0] OFF_OUT = 5'h00;
    localparam logic [4:0] OFF_OE  = 5'h04;
    localparam logic [4:0] OFF_IN  = 5'h08;
    localparam logic [4:0] OFF_SET = 5'h0C;
    localparam logic [4:0] OFF_CLR = 5'h10;
    localparam logic [4:0] OFF_TGL = 5'h14;
    localparam logic [4:0] OFF_IE  = 5'h18;
    localparam logic [4:0] OFF_IS  = 5'h1C;

    localparam int PORT_STRIDE = 32'h20;

endpackage

// File: rtl/gpio_port.sv
// One GPIO port: output/enable registers with atomic set/clear/toggle, a
// two-flop input synchroniser and rising-edge interrupt capture.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [4:0]       off,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] pads,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] out_q, oe_q, ie_q, is_q;
    logic [WIDTH-1:0] s1, s2, prev;
    logic [WIDTH-1:0] rise, w1c_mask, is_next;

    assign rise     = s2 & ~prev;
    assign w1c_mask = (we && off == OFF_IS) ? wdata : '0;
    // An edge arriving in the same cycle as a W1C of that bit must survive.
    assign is_next  = (is_q & ~w1c_mask) | (rise & ie_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: synchroniser and edge flops are reset too, so no phantom edge follows reset.
            out_q <= '0;
            oe_q  <= '0;
            ie_q  <= '0;
            is_q  <= '0;
            s1    <= '0;
            s2    <= '0;
            prev  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            s1   <= pads;
            s2   <= s1;
            prev <= s2;
            is_q <= is_next;
            if (we) begin
                case (off)
                    OFF_OUT: out_q <= wdata;
                    OFF_OE:  oe_q  <= wdata;
                    OFF_SET: out_q <= out_q | wdata;
                    OFF_CLR: out_q <= out_q & ~wdata;
                    OFF_TGL: out_q <= out_q ^ wdata;
                    OFF_IE:  ie_q  <= wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves rdata unassigned (no latch).
        rdata = '0;
        case (off)
            OFF_OUT: rdata = out_q;
            OFF_OE:  rdata = oe_q;
            OFF_IN:  rdata = s2;
            OFF_IE:  rdata = ie_q;
            OFF_IS:  rdata = is_q;
            default: rdata = '0;
        endcase
    end

    assign dout = out_q;
    assign oe   = oe_q;
    assign irq  = |(is_q & ie_q);

endmodule

// File: rtl/ahbl_gpio_bank.sv
// AHB-Lite slave window over NPORTS GPIO ports: address-phase register,
// port decode, read-data mux and the combined interrupt line.
module ahbl_gpio_bank
    import gpio_pkg::*;
#(
    parameter int NPORTS = 3,
    parameter int WIDTH  = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic                    HREADY,
    input  logic [31:0]             HWDATA,
    output logic [31:0]             HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [NPORTS*WIDTH-1:0] GPIO_OUT,
    output logic [NPORTS*WIDTH-1:0] GPIO_OE,
    input  logic [NPORTS*WIDTH-1:0] GPIO_IN,
    output logic                    IRQ
);

    localparam int PORT_SHIFT = $clog2(PORT_STRIDE);

    logic                 dp_valid, dp_write;
    logic [7:0]           dp_addr;
    logic [7-PORT_SHIFT:0] dp_port;
    logic                 dp_aligned;
    logic                 addr_phase;

    logic [NPORTS-1:0]    port_we;
    logic [NPORTS-1:0]    port_irq;
    logic [WIDTH-1:0]     port_rd [NPORTS];
    logic [WIDTH-1:0]     rd_sel;

    assign addr_phase = HSEL & HTRANS[1] & HREADY;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
        end else begin
            dp_valid <= addr_phase;
            if (addr_phase) begin
                dp_write <= HWRITE;
                dp_addr  <= HADDR[7:0];
            end
        end
    end

    assign dp_port    = dp_addr[7:PORT_SHIFT];
    assign dp_aligned = (dp_addr[1:0] == 2'b00);

    // Port indices at or above NPORTS simply never match, so they decode to nothing.
    always_comb begin
        port_we = '0;
        rd_sel  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (int'(dp_port) == p && dp_valid && dp_aligned) begin
                port_we[p] = dp_write;
                if (!dp_write) rd_sel = port_rd[p];
            end
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        gpio_port #(.WIDTH(WIDTH)) u_port (
            .clk   (HCLK),
            .rst   (HRESET),
            .we    (port_we[p]),
            .off   (dp_addr[4:0]),
            .wdata (HWDATA[WIDTH-1:0]),
            .pads  (GPIO_IN[p*WIDTH +: WIDTH]),
            .rdata (port_rd[p]),
            .dout  (GPIO_OUT[p*WIDTH +: WIDTH]),
            .oe    (GPIO_OE[p*WIDTH +: WIDTH]),
            .irq   (port_irq[p])
        );
    end

    assign HRDATA    = 32'(rd_sel);
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign IRQ       = |port_irq;

    logic unused_bus;
    assign unused_bus = ^{HADDR[31:8], HTRANS[0], HSIZE};

    if (WIDTH < 32) begin : g_unused_wdata
        logic unused_hi;
        assign unused_hi = ^HWDATA[31:WIDTH];
    end

endmodule

// File: tb/tb_ahbl_gpio_bank.sv
// Directed bench for ahbl_gpio_bank (3 ports x 32 bits): register map,
// atomic writes, interrupt timing, decode holes, pipelining and reset.
module tb_ahbl_gpio_bank;

    localparam int NPORTS = 3;
    localparam int WIDTH  = 32;
    localparam int NB     = NPORTS * WIDTH;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic          HREADY;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [NB-1:0] GPIO_OUT;
    logic [NB-1:0] GPIO_OE;
    logic [NB-1:0] GPIO_IN;
    logic          IRQ;

    int vectors     = 0;
    int miscompares = 0;

    ahbl_gpio_bank #(.NPORTS(NPORTS), .WIDTH(WIDTH)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .GPIO_OUT  (GPIO_OUT),
        .GPIO_OE   (GPIO_OE),
        .GPIO_IN   (GPIO_IN),
        .IRQ       (IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Address phase, then data phase; returns just after the commit edge.
    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = data;
        tick();
    endtask

    // Returns with HRDATA sampled inside the data phase.
    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        for (int p = 0; p < NPORTS; p++) begin
            for (int r = 0; r < 8; r++) begin
                ahb_read(32'(p * 32 + r * 4), rd);
                vectors++;
                if (rd !== 32'h0) begin
                    miscompares++;
                    $display("FAIL reset_read p%0d off%0h: got %h want 00000000", p, r * 4, rd);
                end
            end
        end
        vectors++;
        if (IRQ !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_irq: got %b want 0", IRQ);
        end
        vectors++;
        if (GPIO_OE !== '0) begin
            miscompares++;
            $display("FAIL reset_oe: got %h want 0", GPIO_OE);
        end
        vectors++;
        if (GPIO_OUT !== '0) begin
            miscompares++;
            $display("FAIL reset_out: got %h want 0", GPIO_OUT);
        end
    endtask

    task automatic test_atomic();
        logic [31:0] rd;
        ahb_write(32'h20, 32'h0000_00F0);
        ahb_write(32'h2C, 32'h0000_000F);
        ahb_write(32'h30, 32'h0000_0030);
        ahb_write(32'h34, 32'h0000_0101);
        ahb_read(32'h20, rd);
        vectors++;
        if (rd !== 32'h0000_01CE) begin
            miscompares++;
            $display("FAIL atomic_readback: got %h want 000001ce", rd);
        end
        vectors++;
        if (GPIO_OUT[63:32] !== 32'h0000_01CE) begin
            miscompares++;
            $display("FAIL atomic_pins: got %h want 000001ce", GPIO_OUT[63:32]);
        end
        vectors++;
        if (GPIO_OUT[31:0] !== 32'h0 || GPIO_OUT[95:64] !== 32'h0) begin
            miscompares++;
            $display("FAIL atomic_other_ports: got %h want 0 outside port 1", GPIO_OUT);
        end
        ahb_read(32'h2C, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL set_reads_zero: got %h want 00000000", rd);
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        logic        want;
        ahb_write(32'h58, 32'h1);
        GPIO_IN[64] = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            want = (e == 3);
            vectors++;
            if (IRQ !== want) begin
                miscompares++;
                $display("FAIL irq_latency edge%0d: got %b want %b", e, IRQ, want);
            end
        end
        ahb_read(32'h5C, rd);
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL irq_status: got %h want 00000001", rd);
        end
        ahb_read(32'h48, rd);
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL in_sync: got %h want 00000001", rd);
        end
        ahb_write(32'h5C, 32'h1);
        vectors++;
        if (IRQ !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_w1c: got %b want 0", IRQ);
        end
        // Edge on a masked bit is dropped; enabling later must not resurrect it.
        GPIO_IN[65] = 1'b1;
        repeat (4) tick();
        ahb_write(32'h58, 32'h3);
        repeat (3) tick();
        ahb_read(32'h5C, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL masked_edge: got %h want 00000000", rd);
        end
        vectors++;
        if (IRQ !== 1'b0) begin
            miscompares++;
            $display("FAIL masked_irq: got %b want 0", IRQ);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] rd;
        ahb_write(32'h18, 32'h2);
        GPIO_IN[1] = 1'b1;
        repeat (3) tick();
        ahb_read(32'h1C, rd);
        vectors++;
        if (rd !== 32'h2) begin
            miscompares++;
            $display("FAIL race_prime: got %h want 00000002", rd);
        end
        GPIO_IN[1] = 1'b0;
        repeat (3) tick();
        // Rise reaches s2 two edges later, exactly when the W1C commits.
        GPIO_IN[1] = 1'b1;
        tick();
        ahb_write(32'h1C, 32'h2);
        ahb_read(32'h1C, rd);
        vectors++;
        if (rd !== 32'h2) begin
            miscompares++;
            $display("FAIL set_wins_clear: got %h want 00000002", rd);
        end
        vectors++;
        if (IRQ !== 1'b1) begin
            miscompares++;
            $display("FAIL set_wins_irq: got %b want 1", IRQ);
        end
        ahb_write(32'h1C, 32'h2);
        ahb_read(32'h1C, rd);
        vectors++;
        if (rd !== 32'h0 || IRQ !== 1'b0) begin
            miscompares++;
            $display("FAIL plain_w1c: got is=%h irq=%b want 00000000/0", rd, IRQ);
        end
    endtask

    task automatic test_decode_holes();
        logic [31:0] rd;
        ahb_write(32'h60, 32'hFFFF_FFFF);
        ahb_read(32'h68, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL oob_read: got %h want 00000000", rd);
        end
        vectors++;
        if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin
            miscompares++;
            $display("FAIL oob_resp: got hresp=%b hreadyout=%b want 0/1", HRESP, HREADYOUT);
        end
        vectors++;
        if (GPIO_OUT !== {32'h0, 32'h0000_01CE, 32'h0} || GPIO_OE !== '0) begin
            miscompares++;
            $display("FAIL oob_no_change: got out=%h oe=%h", GPIO_OUT, GPIO_OE);
        end
        ahb_write(32'h01, 32'h0000_00AA);
        ahb_read(32'h00, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL unaligned_write: got %h want 00000000", rd);
        end
        ahb_read(32'h21, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL unaligned_read: got %h want 00000000", rd);
        end
        // BUSY transfer must not register.
        HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 32'h00;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h55;
        tick();
        ahb_read(32'h00, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL busy_ignored: got %h want 00000000", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h04;
        tick();
        HWDATA = 32'hFFFF_FFFF; HWRITE = 1'b0; HADDR = 32'h04;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        rd = HRDATA;
        vectors++;
        if (rd !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL b2b_read: got %h want ffffffff", rd);
        end
        vectors++;
        if (GPIO_OE[31:0] !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL b2b_pins: got %h want ffffffff", GPIO_OE[31:0]);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h24;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0000_1234; HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        ahb_read(32'h24, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_drop_write: got %h want 00000000", rd);
        end
        ahb_read(32'h20, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_clears_out: got %h want 00000000", rd);
        end
        vectors++;
        if (GPIO_OUT !== '0 || GPIO_OE !== '0 || IRQ !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pins: got out=%h oe=%h irq=%b want 0", GPIO_OUT, GPIO_OE, IRQ);
        end
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HREADY = 1'b1; HWDATA = '0; GPIO_IN = '0;
        repeat (3) tick();
        HRESET = 1'b0;
        test_reset();
        test_atomic();
        test_irq();
        test_set_wins();
        test_decode_holes();
        test_back_to_back();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
